openframe_gpio_cfg_sequencer: RTL and testbench
===============================================

// Module: openframe_gpio_cfg_sequencer
// PURPOSE
//  Owns the eight per-pad configuration vectors (oe/ie/schmitt/slew/pullup/pulldown/drive0/drive1)
//  driven into the user-area GPIO pad controls of the 44-pad openframe padframe.
//  A host writes per-pad 8-bit config words into shadow registers over a valid/ready port.
//  A commit request then copies shadow to active in GROUP_SIZE-pad groups, one group per cycle,
//  which bounds simultaneous pad switching. Sits inside the user project, between its control
//  logic and the pad control outputs.
// PARAMETERS
//  NUM_PADS     44     pad count; fixed by the padframe
//  GROUP_SIZE   4      pads updated per commit cycle; 1..NUM_PADS
//  DEFAULT_CFG  8'h02  reset config word: ie=1, all other bits 0 (input, no pulls, no drive)
// PORTS
//  clk           in   1   sole clock
//  resetb        in   1   asynchronous reset, active low
//  req_valid     in   1   config write request
//  req_ready     out  1   write accepted when req_valid&&req_ready
//  req_addr      in   6   pad index 0..63; >=NUM_PADS is out of range
//  req_data      in   8   cfg word: [0]oe [1]ie [2]schmitt [3]slew [4]pullup [5]pulldown [6]drive0 [7]drive1
//  commit        in   1   one-cycle request: copy shadow to active
//  busy          out  1   commit walk in progress
//  commit_done   out  1   one-cycle pulse after the last group is applied
//  addr_err      out  1   sticky: an out-of-range write was accepted; cleared only by reset
//  gpio_oe..gpio_drive1 out NUM_PADS each (8 vectors)  active config, bit i = pad i
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream):
//   - shadow[i] = active[i] = DEFAULT_CFG
//   - req_ready=1, busy=0, commit_done=0, addr_err=0
//   - state=IDLE, group counter=0
//   - Assertion mid-commit aborts the walk; all outputs revert to defaults immediately.
//  Writes:
//   - Accepted only in IDLE (req_ready=!busy).
//   - In-range write updates shadow[addr] at the clock edge; active is untouched.
//   - Out-of-range write is accepted and discarded; sets addr_err.
//  FSM IDLE -> WALK -> DONE -> IDLE:
//   - IDLE: commit=1 -> WALK, grp=0, busy=1 next cycle. commit while busy is ignored (not queued).
//   - Write+commit same cycle: the write lands in shadow, and the walk includes it.
//   - WALK: each cycle copies shadow[grp*G .. grp*G+G-1] (clipped at NUM_PADS-1) to active; grp++.
//     Last group index = ceil(NUM_PADS/G)-1 -> DONE.
//   - DONE: commit_done=1 for one cycle, busy=0 -> IDLE.
//   - Defaults: 11 WALK cycles; first group visible on outputs 2 cycles after the commit edge;
//     commit_done asserts 12 cycles after the commit edge.
//  Outputs:
//   - Registered, glitch-free; pad i changes only in its group's cycle.
//   - No two groups change in the same cycle.
// STRUCTURE
//  Package openframe_pad_cfg_pkg holds:
//   - NUM_PADS and the cfg bit-position localparams (CFG_OE..CFG_DRIVE1)
//   - the cfg_word_t typedef (8 bits)
//   - the FSM state enum {IDLE, WALK, DONE}
//  One sub-module, openframe_pad_cfg_reg, per pad (generate x NUM_PADS):
//   - shadow and active registers
//   - inputs: wr_en, wr_data, apply
//   - output: active word
//  Top level holds the FSM, the group counter, group-decode of apply, and the unpacking
//  of active words into the 8 output vectors.
// TESTING
//  1 Reset: gpio_ie all ones, the 7 other vectors all zeros, req_ready=1, busy=0, addr_err=0.
//  2 Write pad 5 = 8'h41 without commit: outputs unchanged after 20 cycles.
//    Then commit: gpio_oe[5]=1, gpio_drive0[5]=1, gpio_ie[5]=0; commit_done 12 cycles after the commit edge.
//  3 Write all 44 pads = 8'h01, then commit: each cycle exactly 4 pads (last group 4) flip to oe=1,
//    in index order; busy high 11 cycles; req_ready low throughout.
//  4 Write addr 50: addr_err=1 (stays 1); no output changes. Second commit during busy: ignored,
//    only one commit_done.
//  5 Write pad 43 = 8'h10 in the same cycle as commit: gpio_pullup[43]=1 after the walk.
//  6 resetb low during walk cycle 6: outputs return to defaults immediately, busy=0.
//    After release, a commit reapplies DEFAULT_CFG everywhere.

Source files
------------

// File: rtl/openframe_pad_cfg_pkg.sv
// Shared definitions for the openframe GPIO pad configuration sequencer.
//   NUM_PADS        pad count of the openframe padframe
//   CFG_*           bit positions inside a per-pad config word
//   cfg_word_t      8-bit per-pad config word
//   state_t         commit-walk FSM states
//   ceil_div        integer ceiling division used for group counts
package openframe_pad_cfg_pkg;

  localparam int NUM_PADS = 44;

  localparam int CFG_OE       = 0;
  localparam int CFG_IE       = 1;
  localparam int CFG_SCHMITT  = 2;
  localparam int CFG_SLEW     = 3;
  localparam int CFG_PULLUP   = 4;
  localparam int CFG_PULLDOWN = 5;
  localparam int CFG_DRIVE0   = 6;
  localparam int CFG_DRIVE1   = 7;

  typedef logic [7:0] cfg_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/openframe_pad_cfg_reg.sv
// Per-pad shadow/active config register pair.
//   clk, resetb   clock, async active-low reset (both registers -> DEFAULT_CFG)
//   wr_en         load wr_data into the shadow register
//   wr_data       new shadow config word
//   apply         copy shadow into active
//   active        config word currently driven toward the pad
module openframe_pad_cfg_reg
  import openframe_pad_cfg_pkg::*;
#(
  parameter cfg_word_t DEFAULT_CFG = 8'h02
) (
  input  logic      clk,
  input  logic      resetb,
  input  logic      wr_en,
  input  cfg_word_t wr_data,
  input  logic      apply,
  output cfg_word_t active
);

  cfg_word_t shadow;

  // wr_en and apply are never high together: writes are only accepted
  // outside the walk, and apply only fires inside it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      shadow <= DEFAULT_CFG;
      active <= DEFAULT_CFG;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (apply) active <= shadow;
    end
  end

endmodule

// File: rtl/openframe_gpio_cfg_sequencer.sv
// GPIO pad configuration sequencer for the 44-pad openframe padframe.
// Host writes land in per-pad shadow registers; a commit walks the pads in
// GROUP_SIZE groups, one group per cycle, copying shadow to active so that
// only one group of pads switches in any given cycle.
//   clk, resetb           clock, async active-low reset
//   req_valid/req_ready   config write handshake (ready = !busy)
//   req_addr, req_data    pad index and config word
//   commit                start a shadow->active walk (ignored unless idle)
//   busy                  walk in progress
//   commit_done           one-cycle pulse after the last group lands
//   addr_err              sticky out-of-range write flag
//   gpio_*                registered per-pad config vectors, bit i = pad i
module openframe_gpio_cfg_sequencer
  import openframe_pad_cfg_pkg::*;
#(
  parameter int        GROUP_SIZE  = 4,
  parameter cfg_word_t DEFAULT_CFG = 8'h02
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [5:0]          req_addr,
  input  logic [7:0]          req_data,
  input  logic                commit,
  output logic                busy,
  output logic                commit_done,
  output logic                addr_err,
  output logic [NUM_PADS-1:0] gpio_oe,
  output logic [NUM_PADS-1:0] gpio_ie,
  output logic [NUM_PADS-1:0] gpio_schmitt,
  output logic [NUM_PADS-1:0] gpio_slew,
  output logic [NUM_PADS-1:0] gpio_pullup,
  output logic [NUM_PADS-1:0] gpio_pulldown,
  output logic [NUM_PADS-1:0] gpio_drive0,
  output logic [NUM_PADS-1:0] gpio_drive1
);

  localparam int NUM_GROUPS = ceil_div(NUM_PADS, GROUP_SIZE);
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP  = GW'(NUM_GROUPS - 1);
  localparam logic [6:0]    PAD_LIMIT = 7'(NUM_PADS);

  state_t        state, state_nxt;
  logic [GW-1:0] grp, grp_nxt;
  logic          wr_fire, addr_ok, walking;

  cfg_word_t [NUM_PADS-1:0] active;
  cfg_word_t [NUM_PADS-1:0] out_q;

  assign req_ready = !busy;
  assign wr_fire   = req_valid && req_ready;
  assign addr_ok   = ({1'b0, req_addr} < PAD_LIMIT);
  assign walking   = (state == WALK);

  // FSM: next state and group counter
  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = WALK;
          grp_nxt   = '0;
        end
      end
      WALK: begin
        if (grp == LAST_GRP) begin
          state_nxt = DONE;
          grp_nxt   = '0;
        end else begin
          grp_nxt = grp + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy and commit_done are flops so the status outputs never glitch
  // on a state-bit transition.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      grp         <= '0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      grp         <= grp_nxt;
      busy        <= (state_nxt == WALK);
      commit_done <= (state == DONE);
      if (wr_fire && !addr_ok) addr_err <= 1'b1;
    end
  end

  // Output register: pad pins only ever see flop outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) out_q <= {NUM_PADS{DEFAULT_CFG}};
    else         out_q <= active;
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    localparam logic [GW-1:0] PAD_GRP = GW'(i / GROUP_SIZE);
    logic wr_en, apply;

    assign wr_en = wr_fire && addr_ok && (req_addr == 6'(i));
    assign apply = walking && (grp == PAD_GRP);

    openframe_pad_cfg_reg #(
      .DEFAULT_CFG (DEFAULT_CFG)
    ) u_reg (
      .clk     (clk),
      .resetb  (resetb),
      .wr_en   (wr_en),
      .wr_data (req_data),
      .apply   (apply),
      .active  (active[i])
    );

    assign gpio_oe[i]       = out_q[i][CFG_OE];
    assign gpio_ie[i]       = out_q[i][CFG_IE];
    assign gpio_schmitt[i]  = out_q[i][CFG_SCHMITT];
    assign gpio_slew[i]     = out_q[i][CFG_SLEW];
    assign gpio_pullup[i]   = out_q[i][CFG_PULLUP];
    assign gpio_pulldown[i] = out_q[i][CFG_PULLDOWN];
    assign gpio_drive0[i]   = out_q[i][CFG_DRIVE0];
    assign gpio_drive1[i]   = out_q[i][CFG_DRIVE1];
  end

endmodule

// File: tb/tb_openframe_gpio_cfg_sequencer.sv
// Self-checking bench for openframe_gpio_cfg_sequencer: directed scenarios
// followed by random traffic, all checked every cycle against a timing
// model built from edge counts (commit edge c: pad i lands at c+2+i/4,
// busy after edges c..c+10, commit_done after edge c+12).
module tb_openframe_gpio_cfg_sequencer;

  localparam int NP = 44;

  logic          clk = 1'b0;
  logic          resetb;
  logic          req_valid, req_ready, commit, busy, commit_done, addr_err;
  logic [5:0]    req_addr;
  logic [7:0]    req_data;
  logic [NP-1:0] gpio_oe, gpio_ie, gpio_schmitt, gpio_slew;
  logic [NP-1:0] gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1;

  int checks = 0;
  int errors = 0;

  openframe_gpio_cfg_sequencer dut (
    .clk           (clk),
    .resetb        (resetb),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .commit        (commit),
    .busy          (busy),
    .commit_done   (commit_done),
    .addr_err      (addr_err),
    .gpio_oe       (gpio_oe),
    .gpio_ie       (gpio_ie),
    .gpio_schmitt  (gpio_schmitt),
    .gpio_slew     (gpio_slew),
    .gpio_pullup   (gpio_pullup),
    .gpio_pulldown (gpio_pulldown),
    .gpio_drive0   (gpio_drive0),
    .gpio_drive1   (gpio_drive1)
  );

  always #5 clk = ~clk;

  // reference model
  int         n = 0;
  int         c_last;
  logic [7:0] shadow [NP];
  logic [7:0] snap   [NP];
  logic [7:0] outm   [NP];
  logic       err_m, busy_m, done_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      shadow[i] = 8'h02;
      snap[i]   = 8'h02;
      outm[i]   = 8'h02;
    end
    err_m  = 1'b0;
    busy_m = 1'b0;
    done_m = 1'b0;
    c_last = -100;
  endtask

  task automatic model_edge(input logic v, input logic [5:0] a, input logic [7:0] d, input logic c);
    n++;
    if (v && !busy_m) begin
      if (a < 6'(NP)) shadow[a] = d;
      else            err_m = 1'b1;
    end
    if (c && n >= c_last + 13) begin
      c_last = n;
      for (int i = 0; i < NP; i++) snap[i] = shadow[i];
    end
    for (int i = 0; i < NP; i++)
      if (n == c_last + 2 + i / 4) outm[i] = snap[i];
    busy_m = (n >= c_last) && (n <= c_last + 10);
    done_m = (n == c_last + 12);
  endtask

  function automatic logic [NP-1:0] exp_vec(input int b);
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = outm[i][b];
    return v;
  endfunction

  task automatic check_outputs();
    chk("oe",       64'(gpio_oe),       64'(exp_vec(0)));
    chk("ie",       64'(gpio_ie),       64'(exp_vec(1)));
    chk("schmitt",  64'(gpio_schmitt),  64'(exp_vec(2)));
    chk("slew",     64'(gpio_slew),     64'(exp_vec(3)));
    chk("pullup",   64'(gpio_pullup),   64'(exp_vec(4)));
    chk("pulldown", 64'(gpio_pulldown), 64'(exp_vec(5)));
    chk("drive0",   64'(gpio_drive0),   64'(exp_vec(6)));
    chk("drive1",   64'(gpio_drive1),   64'(exp_vec(7)));
    chk("busy",     64'(busy),          64'(busy_m));
    chk("ready",    64'(req_ready),     64'(!busy_m));
    chk("done",     64'(commit_done),   64'(done_m));
    chk("addr_err", 64'(addr_err),      64'(err_m));
  endtask

  // drive one cycle of inputs, advance the model at the edge, check after it
  task automatic step(input logic v, input logic [5:0] a, input logic [7:0] d, input logic c);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    commit    = c;
    @(posedge clk);
    model_edge(v, a, d, c);
    #1;
    check_outputs();
    req_valid = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 6'd0, 8'd0, 1'b0);
  endtask

  initial begin
    resetb    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    commit    = 1'b0;
    model_reset();
    #12;
    check_outputs();
    chk("rst_ie_ones", 64'(gpio_ie), 64'({NP{1'b1}}));
    resetb = 1'b1;

    // pad 5 write without commit, then commit
    step(1'b1, 6'd5, 8'h41, 1'b0);
    idle(20);
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(13);
    chk("pad5_oe",  64'(gpio_oe[5]),     64'd1);
    chk("pad5_d0",  64'(gpio_drive0[5]), 64'd1);
    chk("pad5_ie",  64'(gpio_ie[5]),     64'd0);

    // every pad to oe-only, then walk
    for (int i = 0; i < NP; i++) step(1'b1, 6'(i), 8'h01, 1'b0);
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(14);
    chk("all_oe", 64'(gpio_oe), 64'({NP{1'b1}}));

    // out-of-range write, and a second commit while busy
    step(1'b1, 6'd50, 8'hff, 1'b0);
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(3);
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(14);

    // write in the same cycle as commit
    step(1'b1, 6'd43, 8'h10, 1'b1);
    idle(14);
    chk("pad43_pu", 64'(gpio_pullup[43]), 64'd1);

    // reset during walk cycle 6
    step(1'b1, 6'd0, 8'hc3, 1'b0);
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(6);
    resetb = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    resetb = 1'b1;
    step(1'b0, 6'd0, 8'h00, 1'b1);
    idle(14);

    // random traffic
    for (int k = 0; k < 800; k++)
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom), 1'($urandom_range(0, 15) == 0));
    idle(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
